// File: rtl/c64_pkg.sv
// Shared definitions for the main-RAM arbitration slice: requester indices,
// arbiter state encoding and the power-on fill pattern.
package c64_pkg;

    // Requester slot indices into the grant / rvalid vectors ({cpu,dma,vic})
    localparam int REQ_VIC = 0;
    localparam int REQ_DMA = 1;
    localparam int REQ_CPU = 2;
    localparam int NUM_REQ = 3;

    // CPU starvation counter width; MAX_WAIT is limited to 1..15
    localparam int WAIT_W = 4;

    // Widest data bus the fill pattern can serve; callers slice what they need
    localparam int FILL_W = 64;

    // INIT only ever moves to RUN; RUN holds until reset
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Power-on pattern: four locations of zeros, then four of ones, repeating
    function automatic logic [FILL_W-1:0] fill_byte(input logic [31:0] addr);
        logic ones;
        ones = (((addr >> 2) & 32'd1) != 32'd0);
        return ones ? {FILL_W{1'b1}} : {FILL_W{1'b0}};
    endfunction

endpackage

// File: rtl/ram_fill_seq.sv
// Power-on fill sequencer: walks an address counter across the whole RAM
// once, one location per step, and raises done when the top address has
// been written.
module ram_fill_seq
    import c64_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  last,
    output logic                  done
);

    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  advance;

    assign advance = step && !done_q;

    // Next counter / done: wrap to zero and finish on the all-ones address
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        last   = 1'b0;
        if (advance) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                done_d = 1'b1;
                last   = 1'b1;
            end
        end
    end

    // Counter and done flag registers; with the fill disabled we start done
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= ~INIT_EN;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/ram_arbiter.sv
// Main-RAM arbiter: after an optional power-on fill, shares the single-port
// RAM between VIC (read-only), DMA and CPU with fixed priority VIC > DMA > CPU
// and a starvation override that lets a refused CPU win after MAX_WAIT
// enabled cycles. Grants and RAM controls are combinational on the current
// requests; read data returns one enabled cycle after issue.
module ram_arbiter
    import c64_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter bit INIT_EN    = 1'b1,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cen,
    input  logic                  vic_req,
    input  logic [ADDR_WIDTH-1:0] vic_a,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_a,
    input  logic [DATA_WIDTH-1:0] dma_di,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_a,
    input  logic [DATA_WIDTH-1:0] cpu_di,
    output logic                  vic_gnt,
    output logic                  dma_gnt,
    output logic                  cpu_gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  init_done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_e            state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_gnt;
    logic                  in_init;
    logic                  fill_active;
    logic                  cpu_force;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  fill_last;
    logic                  fill_done;
    logic [FILL_W-1:0]     fill_word;

    assign in_init     = (state_q == ST_INIT);
    assign fill_active = !reset && cen && in_init;
    assign cpu_force   = cpu_req && (wait_q == WAIT_MAX);
    assign fill_word   = fill_byte(32'(fill_cnt));

    ram_fill_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_EN    (INIT_EN)
    ) u_fill (
        .clk   (clk),
        .reset (reset),
        .step  (cen && in_init),
        .cnt   (fill_cnt),
        .last  (fill_last),
        .done  (fill_done)
    );

    // Grant selection: nothing during reset, INIT or disabled cycles; a
    // starved CPU pre-empts the fixed VIC > DMA > CPU order
    always_comb begin
        gnt = '0;
        if (!reset && cen && !in_init) begin
            if (cpu_force) begin
                gnt[REQ_CPU] = 1'b1;
            end else if (vic_req) begin
                gnt[REQ_VIC] = 1'b1;
            end else if (dma_req) begin
                gnt[REQ_DMA] = 1'b1;
            end else if (cpu_req) begin
                gnt[REQ_CPU] = 1'b1;
            end
        end
    end

    // Reads among the grants; VIC never writes
    assign rd_gnt = gnt & {~cpu_we, ~dma_we, 1'b1};

    // RAM port drive: fill pattern in INIT, otherwise the winner's bus
    always_comb begin
        ram_en = 1'b0;
        ram_we = 1'b0;
        ram_a  = '0;
        ram_di = '0;
        if (fill_active) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            ram_a  = fill_cnt;
            ram_di = fill_word[DATA_WIDTH-1:0];
        end else if (gnt[REQ_CPU]) begin
            ram_en = 1'b1;
            ram_we = cpu_we;
            ram_a  = cpu_a;
            ram_di = cpu_di;
        end else if (gnt[REQ_DMA]) begin
            ram_en = 1'b1;
            ram_we = dma_we;
            ram_a  = dma_a;
            ram_di = dma_di;
        end else if (gnt[REQ_VIC]) begin
            ram_en = 1'b1;
            ram_we = 1'b0;
            ram_a  = vic_a;
        end
    end

    // Next state, CPU wait counter and read-return tracking; all hold when cen=0
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (cen) begin
            if (rvalid_q != '0) begin
                rdata_d = ram_do;
            end
            if (in_init) begin
                rvalid_d = '0;
                if (fill_last) begin
                    state_d = ST_RUN;
                end
            end else begin
                rvalid_d = rd_gnt;
                if (cpu_req && !gnt[REQ_CPU]) begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                end else begin
                    wait_d = '0;
                end
            end
        end
    end

    // Control and read-return registers; reset drops any pending read
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT_EN ? ST_INIT : ST_RUN;
            wait_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // The RAM output is valid while rvalid is up; afterwards the captured copy holds
    assign rdata     = (rvalid_q != '0) ? ram_do : rdata_q;
    assign rvalid    = rvalid_q;
    assign vic_gnt   = gnt[REQ_VIC];
    assign dma_gnt   = gnt[REQ_DMA];
    assign cpu_gnt   = gnt[REQ_CPU];
    assign init_done = fill_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small synchronous RAM model attached.
module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, cen;
    logic          vic_req, dma_req, dma_we, cpu_req, cpu_we;
    logic [AW-1:0] vic_a, dma_a, cpu_a;
    logic [DW-1:0] dma_di, cpu_di;
    logic          vic_gnt, dma_gnt, cpu_gnt, init_done;
    logic [2:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do = '0;
    logic [DW-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fill_tab [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                     8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears after the issuing edge
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_a] <= ram_di;
            else        ram_do <= mem[ram_a];
        end
    end

    ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_EN    (1'b1),
        .MAX_WAIT   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cen       (cen),
        .vic_req   (vic_req),
        .vic_a     (vic_a),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_a     (dma_a),
        .dma_di    (dma_di),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_a     (cpu_a),
        .cpu_di    (cpu_di),
        .vic_gnt   (vic_gnt),
        .dma_gnt   (dma_gnt),
        .cpu_gnt   (cpu_gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .init_done (init_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cen = 1'b1;
        vic_req = 1'b0; vic_a = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_a = '0; dma_di = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_di = '0;

        // Reset values
        #1;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 0);
        tick();
        chk("rst_init_done", init_done, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);

        // Test 1: power-on fill with a CPU read held off
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 4'h5;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_a", ram_a, i);
            chk("fill_en", ram_en, 1);
            chk("fill_we", ram_we, 1);
            chk("fill_di", ram_di, fill_tab[i]);
            chk("fill_no_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 0);
            chk("fill_not_done", init_done, 0);
            tick();
            #1;
        end
        chk("init_done_rise", init_done, 1);
        chk("held_cpu_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b100);
        chk("held_cpu_a", ram_a, 4'h5);
        chk("held_cpu_we", ram_we, 0);
        tick();
        cpu_req = 1'b0;
        chk("held_cpu_rvalid", rvalid, 3'b100);
        chk("held_cpu_rdata", rdata, 8'hFF);

        // Test 2: all three request together, VIC wins
        vic_req = 1'b1; vic_a = 4'h6;
        dma_req = 1'b1; dma_a = 4'h1;
        cpu_req = 1'b1; cpu_a = 4'h2;
        #1;
        chk("prio_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b001);
        chk("prio_a", ram_a, 4'h6);
        chk("prio_we", ram_we, 0);
        tick();
        vic_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
        chk("prio_rvalid", rvalid, 3'b001);
        chk("prio_rdata", rdata, 8'hFF);
        #1;
        chk("idle_en", ram_en, 0);
        chk("idle_we", ram_we, 0);
        chk("idle_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 0);
        tick();
        chk("idle_rvalid", rvalid, 0);

        // Test 3: CPU starvation override after three refusals
        vic_req = 1'b1; vic_a = 4'h0;
        cpu_req = 1'b1; cpu_a = 4'h7;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("starve_vic_gnt", vic_gnt, 1);
            chk("starve_cpu_gnt", cpu_gnt, 0);
            tick();
            chk("starve_vic_rvalid", rvalid, 3'b001);
            chk("starve_vic_rdata", rdata, 8'h00);
            #1;
        end
        chk("force_cpu_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b100);
        chk("force_cpu_a", ram_a, 4'h7);
        tick();
        cpu_req = 1'b0;
        chk("force_rvalid", rvalid, 3'b100);
        chk("force_rdata", rdata, 8'hFF);
        #1;
        chk("after_force_vic", {cpu_gnt, dma_gnt, vic_gnt}, 3'b001);
        tick();
        vic_req = 1'b0;
        chk("after_force_rvalid", rvalid, 3'b001);
        chk("after_force_rdata", rdata, 8'h00);
        tick();

        // Test 4: DMA write then CPU read-back
        dma_req = 1'b1; dma_we = 1'b1; dma_a = 4'h4; dma_di = 8'hA5;
        #1;
        chk("dma_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b010);
        chk("dma_we", ram_we, 1);
        chk("dma_a", ram_a, 4'h4);
        chk("dma_di", ram_di, 8'hA5);
        tick();
        dma_req = 1'b0; dma_we = 1'b0;
        chk("write_no_rvalid", rvalid, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 4'h4;
        #1;
        chk("rb_cpu_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b100);
        chk("rb_we", ram_we, 0);
        tick();
        cpu_req = 1'b0;
        chk("rb_rvalid", rvalid, 3'b100);
        chk("rb_rdata", rdata, 8'hA5);
        tick();

        // Test 5: cen low freezes grants and the wait counter
        vic_req = 1'b1; vic_a = 4'h4;
        cpu_req = 1'b1; cpu_a = 4'h0;
        #1;
        chk("cen_a_vic", vic_gnt, 1);
        tick();
        chk("cen_a_rvalid", rvalid, 3'b001);
        chk("cen_a_rdata", rdata, 8'hA5);
        cen = 1'b0;
        #1;
        chk("cen0_en", ram_en, 0);
        chk("cen0_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 0);
        tick();
        chk("cen0_rvalid_hold", rvalid, 3'b001);
        chk("cen0_rdata_hold", rdata, 8'hA5);
        cen = 1'b1;
        #1;
        chk("cen_c_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b001);
        tick();
        #1;
        chk("cen_d_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b001);
        tick();
        #1;
        chk("cen_e_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b100);
        tick();
        cpu_req = 1'b0; vic_req = 1'b0;
        chk("cen_e_rvalid", rvalid, 3'b100);
        chk("cen_e_rdata", rdata, 8'h00);

        // Test 6: reset over a RUN read, then again in the middle of the fill
        vic_req = 1'b1; vic_a = 4'h4;
        reset = 1'b1;
        #1;
        chk("rrst_vic_gnt", vic_gnt, 0);
        chk("rrst_en", ram_en, 0);
        tick();
        reset = 1'b0;
        chk("rrst_rvalid", rvalid, 0);
        chk("rrst_init_done", init_done, 0);
        chk("rrst_rdata", rdata, 0);
        #1;
        chk("rrst_fill_we", ram_we, 1);
        for (int i = 0; i < 9; i++) begin
            chk("refill_a", ram_a, i);
            chk("refill_no_gnt", vic_gnt, 0);
            tick();
            if (i == 2) begin
                cen = 1'b0;
                #1;
                chk("fill_cen0_en", ram_en, 0);
                tick();
                cen = 1'b1;
            end
            #1;
        end
        chk("fill_at_9", ram_a, 4'h9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("fill_restart_a", ram_a, 0);
        chk("fill_restart_done", init_done, 0);
        chk("fill_restart_rvalid", rvalid, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            #1;
        end
        chk("refill_done", init_done, 1);
        chk("refill_vic_gnt", {cpu_gnt, dma_gnt, vic_gnt}, 3'b001);
        chk("refill_vic_a", ram_a, 4'h4);
        tick();
        vic_req = 1'b0;
        chk("refill_rvalid", rvalid, 3'b001);
        chk("refill_rdata", rdata, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
